// File: rtl/store_buffer_pkg.sv
// Shared store-path types: op encodings, buffered entry layout and the byte-enable helper.
// The byte-enable helper is also used by the load-extension path.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    ST_SW      = 2'd0,
    ST_SH      = 2'd1,
    ST_SB      = 2'd2,
    ST_ILLEGAL = 2'd3
  } st_op_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } sb_entry_t;

  function automatic logic [3:0] byte_en(input st_op_e op, input logic [1:0] off);
    case (op)
      ST_SW:   return 4'b1111;
      ST_SH:   return off[1] ? 4'b1100 : 4'b0011;
      ST_SB:   return 4'b0001 << off;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane alignment: byte enables, lane-replicated data and misalign flag.
// Purely combinational, zero latency, no flow control.
module store_align
  import store_buffer_pkg::*;
(
  input  st_op_e      op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  assign be_o = byte_en(op_i, off_i);

  always_comb begin
    wdata_o    = data_i;
    misalign_o = 1'b0;
    case (op_i)
      ST_SW: misalign_o = (off_i != 2'b00);
      ST_SH: begin
        wdata_o    = {2{data_i[15:0]}};
        misalign_o = off_i[0];
      end
      ST_SB:   wdata_o    = {4{data_i[7:0]}};
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: aligned stores queue and drain head-first to data memory (1-cycle push-to-mem_we).
// st_ready drops when DEPTH entries are held; head holds stable until mem_ack.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  sb_entry_t     ent_q [DEPTH];

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misalign;
  logic        accept, push, pop;

  store_align u_align (
    .op_i       (st_op_e'(st_op)),
    .off_i      (st_addr[1:0]),
    .data_i     (st_data),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .misalign_o (al_misalign)
  );

  assign st_ready = (count_q < CW'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign push     = accept && !al_misalign;
  assign sb_empty = (count_q == '0);
  assign mem_we   = !sb_empty;
  assign pop      = mem_we && mem_ack;
  assign st_err   = err_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = accept && al_misalign;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload is only observed through count-qualified paths, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) ent_q[tail_q] <= '{waddr: st_addr[31:2], be: al_be, wdata: al_wdata};
  end

  assign mem_addr  = {ent_q[head_q].waddr, 2'b00};
  assign mem_be    = ent_q[head_q].be;
  assign mem_wdata = ent_q[head_q].wdata;

  logic unused_ld_off;
  assign unused_ld_off = ^ld_addr[1:0];

  always_comb begin
    logic [PW-1:0] age;
    ld_hit = 1'b0;
    age    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PW'(i) - head_q;
      if (({1'b0, age} < count_q) && (ent_q[i].waddr == ld_addr[31:2])) ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4): alignment, errors, full/wrap, push+pop, load hit, reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        sb_empty;

  int n_assert = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_err    (st_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_st(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    reset_n = 1'b0;
    mem_ack = 1'b0;
    ld_addr = 32'h0;
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_mem_we",   {31'b0, mem_we},   32'd0);
    chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_st_err",   {31'b0, st_err},   32'd0);
    chk("rst_ld_hit",   {31'b0, ld_hit},   32'd0);

    // SB to lane 3; no same-cycle bypass.
    drive_st(1'b1, 2'd2, 32'h0000_1003, 32'h0000_00A5);
    #1;
    chk("sb_no_bypass", {31'b0, mem_we}, 32'd0);
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    chk("sb_mem_we",    {31'b0, mem_we}, 32'd1);
    chk("sb_mem_addr",  mem_addr,        32'h0000_1000);
    chk("sb_mem_be",    {28'b0, mem_be}, 32'h8);
    chk("sb_mem_wdata", mem_wdata,       32'hA5A5_A5A5);
    chk("sb_no_err",    {31'b0, st_err}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("sb_drained", {31'b0, sb_empty}, 32'd1);

    // SH upper half.
    drive_st(1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF);
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    chk("sh_mem_addr",  mem_addr,        32'h0000_2000);
    chk("sh_mem_be",    {28'b0, mem_be}, 32'hC);
    chk("sh_mem_wdata", mem_wdata,       32'hBEEF_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Misaligned SH: one-cycle error, nothing enqueued.
    drive_st(1'b1, 2'd1, 32'h0000_2001, 32'h1234_BEEF);
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    chk("sh_mis_err",   {31'b0, st_err},   32'd1);
    chk("sh_mis_empty", {31'b0, sb_empty}, 32'd1);
    tick();
    chk("sh_mis_err_drop", {31'b0, st_err},   32'd0);
    chk("sh_mis_empty2",   {31'b0, sb_empty}, 32'd1);

    // Illegal op, then misaligned SW.
    drive_st(1'b1, 2'd3, 32'h0000_2000, 32'h0);
    tick();
    drive_st(1'b1, 2'd0, 32'h0000_2002, 32'h0);
    #1;
    chk("ill_err", {31'b0, st_err}, 32'd1);
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    chk("sw_mis_err",   {31'b0, st_err},   32'd1);
    chk("sw_mis_empty", {31'b0, sb_empty}, 32'd1);

    // Fill with four SW, fifth held until a pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 2'd0, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
      tick();
    end
    chk("full_not_ready", {31'b0, st_ready}, 32'd0);
    drive_st(1'b1, 2'd0, 32'h0000_0110, 32'h5555_5555);
    tick();
    chk("fifth_held",     {31'b0, st_ready}, 32'd0);
    chk("full_head_addr", mem_addr,          32'h0000_0100);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("slot_freed",   {31'b0, st_ready}, 32'd1);
    chk("pop_head_adr", mem_addr,          32'h0000_0104);
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    chk("fifth_in_full", {31'b0, st_ready}, 32'd0);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_addr", mem_addr,  32'h104 + 32'(4 * k));
      chk("drain_data", mem_wdata, 32'h1111_1111 * 32'(k + 2));
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("drain_empty", {31'b0, sb_empty}, 32'd1);

    // Two entries, then simultaneous push and pop; load-hit tracking.
    drive_st(1'b1, 2'd0, 32'h0000_3000, 32'h0000_000A);
    tick();
    drive_st(1'b1, 2'd0, 32'h0000_3004, 32'h0000_000B);
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    ld_addr = 32'h0000_3001;
    #1;
    chk("ld_hit_3000", {31'b0, ld_hit}, 32'd1);
    ld_addr = 32'h0000_3010;
    #1;
    chk("ld_miss", {31'b0, ld_hit}, 32'd0);
    ld_addr = 32'h0000_3001;
    drive_st(1'b1, 2'd0, 32'h0000_3008, 32'h0000_000C);
    mem_ack = 1'b1;
    tick();
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    mem_ack = 1'b0;
    #1;
    chk("pp_head_addr", mem_addr,         32'h0000_3004);
    chk("ld_hit_gone",  {31'b0, ld_hit},  32'd0);
    ld_addr = 32'h0000_3009;
    #1;
    chk("ld_hit_3008", {31'b0, ld_hit}, 32'd1);
    mem_ack = 1'b1;
    tick();
    chk("pp_count2_addr",  mem_addr,          32'h0000_3008);
    chk("pp_count2_empty", {31'b0, sb_empty}, 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("pp_empty",     {31'b0, sb_empty}, 32'd1);
    chk("ld_hit_empty", {31'b0, ld_hit},   32'd0);

    // Reset mid-drain drops everything.
    for (int i = 0; i < 3; i++) begin
      drive_st(1'b1, 2'd0, 32'h400 + 32'(4 * i), 32'hCAFE_0000 + 32'(i));
      tick();
    end
    drive_st(1'b0, 2'd0, 32'h0, 32'h0);
    ld_addr = 32'h0000_0400;
    #1;
    chk("pre_rst_we",  {31'b0, mem_we}, 32'd1);
    chk("pre_rst_hit", {31'b0, ld_hit}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("mid_rst_we",    {31'b0, mem_we},   32'd0);
    chk("mid_rst_empty", {31'b0, sb_empty}, 32'd1);
    chk("mid_rst_ready", {31'b0, st_ready}, 32'd1);
    chk("mid_rst_hit",   {31'b0, ld_hit},   32'd0);
    tick();
    chk("post_rst_we", {31'b0, mem_we}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
